// File: rtl/w_pipe_if.sv
// Writeback pipeline register bundle: memory-stage results and controls in, W-stage state out.
interface w_pipe_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 32
);
    logic              W_stall;
    logic              W_bubble;
    logic [3:0]        m_stat;
    logic [3:0]        M_icode;
    logic [REG_W-1:0]  m_dstE;
    logic [REG_W-1:0]  m_dstM;
    logic [DATA_W-1:0] m_valE;
    logic [DATA_W-1:0] m_valM;

    logic [3:0]        W_stat;
    logic [3:0]        W_icode;
    logic [REG_W-1:0]  W_dstE;
    logic [REG_W-1:0]  W_dstM;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic              W_wrE;
    logic              W_wrM;
    logic              W_halted;
    logic              W_retire;
    logic [CNT_W-1:0]  W_retired_cnt;
    logic              W_ctrl_err;

    modport master (
        output W_stall, W_bubble, m_stat, M_icode, m_dstE, m_dstM, m_valE, m_valM,
        input  W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
               W_wrE, W_wrM, W_halted, W_retire, W_retired_cnt, W_ctrl_err
    );

    modport slave (
        input  W_stall, W_bubble, m_stat, M_icode, m_dstE, m_dstM, m_valE, m_valM,
        output W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
               W_wrE, W_wrM, W_halted, W_retire, W_retired_cnt, W_ctrl_err
    );
endinterface

// File: rtl/w_pipe_reg.sv
// Writeback-stage pipeline register with stall/bubble control, sticky halt,
// retire pulse and a saturating retired-instruction counter.
module w_pipe_reg #(
    parameter int              DATA_W   = 64,
    parameter int              REG_W    = 4,
    parameter int              CNT_W    = 32,
    parameter logic [3:0]      STAT_AOK = 4'h1,
    parameter logic [REG_W-1:0] RNONE   = 4'hF,
    parameter logic [3:0]      INOP     = 4'h1
) (
    input logic     clk,
    input logic     rst_n,
    w_pipe_if.slave w
);
    logic [3:0]        stat_q;
    logic [3:0]        icode_q;
    logic [REG_W-1:0]  dste_q;
    logic [REG_W-1:0]  dstm_q;
    logic [DATA_W-1:0] vale_q;
    logic [DATA_W-1:0] valm_q;
    logic              halted_q;
    logic              retire_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ctrl_err_q;
    logic              retire_ev;

    assign retire_ev = (w.m_stat == STAT_AOK) && (w.M_icode != INOP);

    // Priority: reset > halted (frozen) > stall > bubble > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q     <= STAT_AOK;
            icode_q    <= INOP;
            dste_q     <= RNONE;
            dstm_q     <= RNONE;
            vale_q     <= '0;
            valm_q     <= '0;
            halted_q   <= 1'b0;
            retire_q   <= 1'b0;
            cnt_q      <= '0;
            ctrl_err_q <= 1'b0;
        end else if (halted_q) begin
            retire_q <= 1'b0;
        end else if (w.W_stall) begin
            retire_q <= 1'b0;
            if (w.W_bubble)
                ctrl_err_q <= 1'b1;
        end else if (w.W_bubble) begin
            stat_q   <= STAT_AOK;
            icode_q  <= INOP;
            dste_q   <= RNONE;
            dstm_q   <= RNONE;
            vale_q   <= '0;
            valm_q   <= '0;
            retire_q <= 1'b0;
        end else begin
            stat_q   <= w.m_stat;
            icode_q  <= w.M_icode;
            dste_q   <= w.m_dstE;
            dstm_q   <= w.m_dstM;
            vale_q   <= w.m_valE;
            valm_q   <= w.m_valM;
            halted_q <= (w.m_stat != STAT_AOK);
            retire_q <= retire_ev;
            // Counter saturates at all-ones rather than wrapping.
            if (retire_ev && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign w.W_stat        = stat_q;
    assign w.W_icode       = icode_q;
    assign w.W_dstE        = dste_q;
    assign w.W_dstM        = dstm_q;
    assign w.W_valE        = vale_q;
    assign w.W_valM        = valm_q;
    assign w.W_halted      = halted_q;
    assign w.W_retire      = retire_q;
    assign w.W_retired_cnt = cnt_q;
    assign w.W_ctrl_err    = ctrl_err_q;
    assign w.W_wrE         = (dste_q != RNONE) && (stat_q == STAT_AOK) && !halted_q;
    assign w.W_wrM         = (dstm_q != RNONE) && (stat_q == STAT_AOK) && !halted_q;
endmodule

// File: tb/tb_w_pipe_reg.sv
// Directed-vector bench for w_pipe_reg; a second instance with a 4-bit counter checks saturation.
module tb_w_pipe_reg;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    w_pipe_if #(.DATA_W(64), .REG_W(4), .CNT_W(32)) wif ();
    w_pipe_if #(.DATA_W(64), .REG_W(4), .CNT_W(4))  sif ();

    w_pipe_reg #(.DATA_W(64), .REG_W(4), .CNT_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (wif.slave)
    );

    w_pipe_reg #(.DATA_W(64), .REG_W(4), .CNT_W(4)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives both instances identically, then advances one edge and settles.
    task automatic applyStimulus(input logic stall, input logic bubble,
                                 input logic [3:0] stat, input logic [3:0] icode,
                                 input logic [3:0] dste, input logic [3:0] dstm,
                                 input logic [63:0] vale, input logic [63:0] valm);
        wif.W_stall = stall;  sif.W_stall = stall;
        wif.W_bubble = bubble; sif.W_bubble = bubble;
        wif.m_stat = stat;    sif.m_stat = stat;
        wif.M_icode = icode;  sif.M_icode = icode;
        wif.m_dstE = dste;    sif.m_dstE = dste;
        wif.m_dstM = dstm;    sif.m_dstM = dstm;
        wif.m_valE = vale;    sif.m_valE = vale;
        wif.m_valM = valm;    sif.m_valM = valm;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_stat"},   64'(wif.W_stat), 64'h1);
        checkOutput({tag, "_icode"},  64'(wif.W_icode), 64'h1);
        checkOutput({tag, "_dstE"},   64'(wif.W_dstE), 64'hF);
        checkOutput({tag, "_dstM"},   64'(wif.W_dstM), 64'hF);
        checkOutput({tag, "_valE"},   wif.W_valE, 64'h0);
        checkOutput({tag, "_valM"},   wif.W_valM, 64'h0);
        checkOutput({tag, "_wrE"},    64'(wif.W_wrE), 64'h0);
        checkOutput({tag, "_wrM"},    64'(wif.W_wrM), 64'h0);
        checkOutput({tag, "_halted"}, 64'(wif.W_halted), 64'h0);
        checkOutput({tag, "_retire"}, 64'(wif.W_retire), 64'h0);
        checkOutput({tag, "_cnt"},    64'(wif.W_retired_cnt), 64'h0);
        checkOutput({tag, "_err"},    64'(wif.W_ctrl_err), 64'h0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h1, 4'h6, 4'h3, 4'h4, 64'h99, 64'h98);
        checkResetState("rst");
        checkOutput("rst_small_cnt", 64'(sif.W_retired_cnt), 64'h0);

        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h1, 4'h6, 4'h3, 4'hF, 64'h55, 64'h11);
        checkOutput("ld1_valE",   wif.W_valE, 64'h55);
        checkOutput("ld1_icode",  64'(wif.W_icode), 64'h6);
        checkOutput("ld1_wrE",    64'(wif.W_wrE), 64'h1);
        checkOutput("ld1_wrM",    64'(wif.W_wrM), 64'h0);
        checkOutput("ld1_retire", 64'(wif.W_retire), 64'h1);
        checkOutput("ld1_cnt",    64'(wif.W_retired_cnt), 64'h1);

        applyStimulus(1'b0, 1'b0, 4'h1, 4'h5, 4'hF, 4'h7, 64'hAA, 64'h1234);
        checkOutput("ld2_valM",   wif.W_valM, 64'h1234);
        checkOutput("ld2_wrE",    64'(wif.W_wrE), 64'h0);
        checkOutput("ld2_wrM",    64'(wif.W_wrM), 64'h1);
        checkOutput("ld2_cnt",    64'(wif.W_retired_cnt), 64'h2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h1, 4'(8 + i), 4'(i), 4'(i + 1),
                          64'(i + 64'h500), 64'(i + 64'h600));
            checkOutput("stall_valM",   wif.W_valM, 64'h1234);
            checkOutput("stall_valE",   wif.W_valE, 64'hAA);
            checkOutput("stall_icode",  64'(wif.W_icode), 64'h5);
            checkOutput("stall_dstM",   64'(wif.W_dstM), 64'h7);
            checkOutput("stall_retire", 64'(wif.W_retire), 64'h0);
            checkOutput("stall_cnt",    64'(wif.W_retired_cnt), 64'h2);
        end

        applyStimulus(1'b0, 1'b1, 4'h1, 4'h6, 4'h3, 4'h3, 64'h77, 64'h88);
        checkOutput("bub_icode",  64'(wif.W_icode), 64'h1);
        checkOutput("bub_dstE",   64'(wif.W_dstE), 64'hF);
        checkOutput("bub_dstM",   64'(wif.W_dstM), 64'hF);
        checkOutput("bub_valE",   wif.W_valE, 64'h0);
        checkOutput("bub_wrE",    64'(wif.W_wrE), 64'h0);
        checkOutput("bub_wrM",    64'(wif.W_wrM), 64'h0);
        checkOutput("bub_cnt",    64'(wif.W_retired_cnt), 64'h2);
        checkOutput("bub_retire", 64'(wif.W_retire), 64'h0);

        // nop load: register written but not a retire event
        applyStimulus(1'b0, 1'b0, 4'h1, 4'h1, 4'h2, 4'hF, 64'h33, 64'h0);
        checkOutput("nop_wrE",    64'(wif.W_wrE), 64'h1);
        checkOutput("nop_retire", 64'(wif.W_retire), 64'h0);
        checkOutput("nop_cnt",    64'(wif.W_retired_cnt), 64'h2);

        applyStimulus(1'b1, 1'b1, 4'h1, 4'h6, 4'h9, 4'h9, 64'hDEAD, 64'hBEEF);
        checkOutput("sb_dstE",   64'(wif.W_dstE), 64'h2);
        checkOutput("sb_valE",   wif.W_valE, 64'h33);
        checkOutput("sb_err",    64'(wif.W_ctrl_err), 64'h1);

        applyStimulus(1'b0, 1'b0, 4'h1, 4'h3, 4'h4, 4'hF, 64'h77, 64'h0);
        checkOutput("post_sb_valE", wif.W_valE, 64'h77);
        checkOutput("post_sb_err",  64'(wif.W_ctrl_err), 64'h1);
        checkOutput("post_sb_cnt",  64'(wif.W_retired_cnt), 64'h3);

        applyStimulus(1'b0, 1'b0, 4'h2, 4'h0, 4'h5, 4'h6, 64'hC0, 64'hC1);
        checkOutput("hlt_halted", 64'(wif.W_halted), 64'h1);
        checkOutput("hlt_stat",   64'(wif.W_stat), 64'h2);
        checkOutput("hlt_wrE",    64'(wif.W_wrE), 64'h0);
        checkOutput("hlt_wrM",    64'(wif.W_wrM), 64'h0);
        checkOutput("hlt_retire", 64'(wif.W_retire), 64'h0);
        checkOutput("hlt_cnt",    64'(wif.W_retired_cnt), 64'h3);

        applyStimulus(1'b0, 1'b0, 4'h1, 4'h6, 4'h1, 4'h1, 64'hF00, 64'hF01);
        checkOutput("frz_ld_stat",  64'(wif.W_stat), 64'h2);
        checkOutput("frz_ld_valE",  wif.W_valE, 64'hC0);
        checkOutput("frz_ld_cnt",   64'(wif.W_retired_cnt), 64'h3);
        applyStimulus(1'b0, 1'b1, 4'h1, 4'h6, 4'h1, 4'h1, 64'hF00, 64'hF01);
        checkOutput("frz_bub_icode", 64'(wif.W_icode), 64'h0);
        checkOutput("frz_bub_dstE",  64'(wif.W_dstE), 64'h5);

        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h1, 4'h6, 4'h1, 4'h1, 64'hF00, 64'hF01);
        checkResetState("rst_halt");

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h1, 4'h7, 4'(i), 4'(i + 8),
                          64'(i * 16 + 1), 64'(i * 16 + 2));
            checkOutput("b2b_valE", wif.W_valE, 64'(i * 16 + 1));
            checkOutput("b2b_dstM", 64'(wif.W_dstM), 64'(i + 8));
            checkOutput("b2b_cnt",  64'(wif.W_retired_cnt), 64'(i + 1));
        end

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h1, 4'h6, 4'h3, 4'hF, 64'(i), 64'h0);
            if (i == 14)
                checkOutput("sat_cnt14", 64'(sif.W_retired_cnt), 64'hE);
            if (i == 15)
                checkOutput("sat_cnt15", 64'(sif.W_retired_cnt), 64'hF);
        end
        checkOutput("sat_cnt17",   64'(sif.W_retired_cnt), 64'hF);
        checkOutput("wide_cnt17",  64'(wif.W_retired_cnt), 64'd17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/w_pipe_reg.md
W_PIPE_REG -- requirements
Module: w_pipe_reg

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
  DATA_W, 64, width of valE/valM
  REG_W, 4, width of register IDs
  CNT_W, 32, width of retire counter
  STAT_AOK, 4'h1, normal status code
  RNONE, 4'hF, "no register" ID
  INOP, 4'h1, nop icode used for bubbles
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  synchronous reset, active low
  W_stall  in  1  hold W contents
  W_bubble  in  1  load a nop bubble
  m_stat  in  4  status from memory stage
  M_icode  in  4  icode from memory stage
  m_dstE, m_dstM  in  REG_W  destination IDs
  m_valE, m_valM  in  DATA_W  result values
  W_stat, W_icode  out  4  registered status/icode
  W_dstE, W_dstM  out  REG_W  registered destinations
  W_valE, W_valM  out  DATA_W  registered values
  W_wrE, W_wrM  out  1  register-file write enables
  W_halted  out  1  sticky halt flag
  W_retire  out  1  one-cycle retire pulse
  W_retired_cnt  out  CNT_W  retired-instruction count
  W_ctrl_err  out  1  sticky stall+bubble conflict flag
REQ-003 SHALL use one clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-004 SHALL resolve each rising edge by priority: reset > halted > stall > bubble > load.
REQ-005 Load (no higher-priority condition): SHALL capture all six m_/M_ inputs into W_ outputs, one-cycle latency.
REQ-006 Stall: SHALL hold all W_ outputs, W_halted and W_retired_cnt; SHALL drive W_retire=0.
REQ-007 Bubble (W_stall=0): SHALL load W_stat=STAT_AOK, W_icode=INOP, W_dstE=W_dstM=RNONE, W_valE=W_valM=0.
REQ-008 W_stall=1 and W_bubble=1 in the same cycle: stall SHALL win; W_ctrl_err SHALL set and stay 1 until reset.
REQ-009 A load capturing m_stat!=STAT_AOK SHALL set W_halted on the same edge.
REQ-010 While W_halted=1: all W_ outputs and the counter SHALL freeze regardless of stall/bubble, until rst_n=0.
REQ-011 Retire event = load with m_stat==STAT_AOK and M_icode!=INOP; SHALL increment W_retired_cnt by 1 on that edge.
REQ-012 W_retired_cnt SHALL saturate at all-ones and never wrap.
REQ-013 W_retire SHALL be registered: 1 for exactly the cycle after a retire event edge, else 0.
REQ-014 W_wrE SHALL equal (W_dstE!=RNONE) && (W_stat==STAT_AOK) && !W_halted, combinational from registers; W_wrM same with W_dstM.
REQ-015 Consecutive loads SHALL each be captured; no cycle SHALL be lost or duplicated.

Reset
REQ-016 With rst_n=0 at an edge, SHALL set W_stat=STAT_AOK, W_icode=INOP, W_dstE=W_dstM=RNONE, W_valE=W_valM=0, W_halted=0, W_retire=0, W_retired_cnt=0, W_ctrl_err=0.
REQ-017 Reset SHALL override stall, bubble and halted state, including mid-stall and after halt.
REQ-018 First edge with rst_n=1 SHALL act per REQ-004.

Verification
REQ-019 Load: m_stat=1, M_icode=6, m_dstE=3, m_valE=0x55 -> next cycle W_valE=0x55, W_wrE=1, W_retire=1, cnt=1.
REQ-020 Stall 3 cycles with changing inputs -> W_ outputs unchanged, W_retire=0, cnt unchanged.
REQ-021 Bubble -> W_icode=1, W_dstE=W_dstM=0xF, W_wrE=W_wrM=0, cnt unchanged; stall+bubble -> hold, W_ctrl_err=1.
REQ-022 m_stat=2 (HLT) loaded -> W_halted=1, W_stat=2, W_wrE=0; further loads/bubbles ignored until rst_n=0, then all reset values.
REQ-023 CNT_W=4: 17 retire events -> cnt stops at 0xF, no wrap.
REQ-024 rst_n=0 during stall with W_halted=1 -> next edge all outputs equal REQ-016 values.
